// File: rtl/bidir_xor_port.sv
// bidir_xor_port: clocked XOR front end for a shared tristate pad bus.
// A drive request puts a^b on pad for one cycle and then loops that value
// back onto d. A receive request samples pad and reports a^pad. Every drive
// is followed by, and every receive is preceded by, TURN_CYCLES idle bus
// cycles, so the pads are never driven while another agent may be driving.
module bidir_xor_port #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             req_valid,
    input  logic             req_dir,
    output logic             req_ready,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] d,
    output logic             d_valid,
    output logic             par,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2,
        RECV  = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [3:0]       turn_cnt;
    logic [3:0]       turn_cnt_nx;
    logic             after_drive;
    logic             after_drive_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] x_q;
    logic             accept;
    logic             oe;
    logic [WIDTH-1:0] rx_val;

    assign req_ready = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;

    // Output enable comes from the state register only, so a request can
    // never cause a combinational glitch onto the bus.
    assign oe     = (state == DRIVE);
    assign pad    = oe ? x_q : {WIDTH{1'bz}};
    assign rx_val = a_q ^ pad;

    // State, turnaround counter and turnaround-direction flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            turn_cnt    <= '0;
            after_drive <= 1'b0;
        end else begin
            state       <= state_nx;
            turn_cnt    <= turn_cnt_nx;
            after_drive <= after_drive_nx;
        end
    end

    // Next-state decode; TURN exits to IDLE after a drive, to RECV before a receive.
    always_comb begin
        state_nx       = state;
        turn_cnt_nx    = turn_cnt;
        after_drive_nx = after_drive;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_dir) begin
                        state_nx = DRIVE;
                    end else begin
                        state_nx       = TURN;
                        turn_cnt_nx    = TURN_LOAD;
                        after_drive_nx = 1'b0;
                    end
                end
            end
            DRIVE: begin
                state_nx       = TURN;
                turn_cnt_nx    = TURN_LOAD;
                after_drive_nx = 1'b1;
            end
            TURN: begin
                if (turn_cnt == 4'd0) begin
                    state_nx = after_drive ? IDLE : RECV;
                end else begin
                    turn_cnt_nx = turn_cnt - 4'd1;
                end
            end
            RECV: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture on accept and result/parity/valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            x_q     <= '0;
            d       <= '0;
            par     <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            if (accept && req_dir) begin
                x_q <= a ^ b;
            end
            if (accept && !req_dir) begin
                a_q <= a;
            end
            if (state == DRIVE) begin
                d       <= x_q;
                par     <= ^x_q;
                d_valid <= 1'b1;
            end
            if (state == RECV) begin
                d       <= rx_val;
                par     <= ^rx_val;
                d_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bidir_xor_port.sv
// Testbench for bidir_xor_port: two instances (TURN_CYCLES 1 and 3), each on
// its own pad bus. The bench drives every pad bus whenever the DUT is not
// expected to drive it, so any stray DUT drive shows up as a corrupted value.
module tb_bidir_xor_port;

    logic       clk = 1'b0;
    logic       rst_n  [2];
    logic [7:0] a      [2];
    logic [7:0] b      [2];
    logic       rv     [2];
    logic       rd     [2];
    logic       rdy    [2];
    logic [7:0] d      [2];
    logic       dv     [2];
    logic       par    [2];
    logic       busy   [2];
    logic       tb_oe  [2];
    logic [7:0] tb_val [2];
    wire  [7:0] pad0;
    wire  [7:0] pad1;

    assign pad0 = tb_oe[0] ? tb_val[0] : 8'bz;
    assign pad1 = tb_oe[1] ? tb_val[1] : 8'bz;

    // Free-running clock.
    always #5 clk = ~clk;

    bidir_xor_port #(.WIDTH(8), .TURN_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .a(a[0]), .b(b[0]),
        .req_valid(rv[0]), .req_dir(rd[0]), .req_ready(rdy[0]),
        .pad(pad0), .d(d[0]), .d_valid(dv[0]), .par(par[0]), .busy(busy[0])
    );

    bidir_xor_port #(.WIDTH(8), .TURN_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .a(a[1]), .b(b[1]),
        .req_valid(rv[1]), .req_dir(rd[1]), .req_ready(rdy[1]),
        .pad(pad1), .d(d[1]), .d_valid(dv[1]), .par(par[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model, one slot per instance. Cycle index n counts edges.
    int         idx      [2];
    int         ready_at [2];
    int         dv_at    [2];
    int         drv_at   [2];
    int         recv_at  [2];
    bit         mvalid   [2];
    logic [7:0] dv_val   [2];
    logic [7:0] d_hold   [2];
    logic [7:0] drv_val  [2];
    logic [7:0] recv_a   [2];
    logic [7:0] last_x   [2];
    bit         fix_en;
    logic [7:0] fix_val;

    function automatic int tc(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    function automatic logic [7:0] pad_of(input int s);
        return (s == 1) ? pad1 : pad0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus for instance s, with model update and checks.
    task automatic step(input int s, input bit v, input bit dir,
                        input logic [7:0] av, input logic [7:0] bv,
                        input bit rn, output bit acc);
        int         n;
        logic [7:0] pv;
        rst_n[s] = rn;
        rv[s]    = v;
        rd[s]    = dir;
        a[s]     = av;
        b[s]     = bv;
        acc = v && rn && mvalid[s] && (idx[s] >= ready_at[s]);
        if (acc && dir) tb_oe[s] = 1'b0;
        #1;
        if (mvalid[s] || !rn)
            chk("req_ready", 8'(rdy[s]), 8'(rn && mvalid[s] && (idx[s] >= ready_at[s])));
        @(posedge clk);
        idx[s]++;
        n = idx[s];
        if (!rn) begin
            ready_at[s] = n;
            dv_at[s]    = -1;
            drv_at[s]   = -1;
            recv_at[s]  = -1;
            d_hold[s]   = 8'h00;
            last_x[s]   = 8'h00;
            mvalid[s]   = 1'b1;
        end else if (acc) begin
            if (dir) begin
                drv_at[s]  = n;
                drv_val[s] = av ^ bv;
                last_x[s]  = av ^ bv;
                dv_at[s]   = n + 1;
                dv_val[s]  = av ^ bv;
            end else begin
                recv_at[s] = n + tc(s);
                recv_a[s]  = av;
            end
            ready_at[s] = n + tc(s) + 1;
        end
        #1;
        if (n == drv_at[s]) begin
            tb_oe[s] = 1'b0;
        end else begin
            if (n == recv_at[s]) begin
                pv        = fix_en ? fix_val : 8'($urandom);
                dv_at[s]  = n + 1;
                dv_val[s] = recv_a[s] ^ pv;
            end else begin
                pv = ~last_x[s];
            end
            tb_val[s] = pv;
            tb_oe[s]  = 1'b1;
        end
        if (n == dv_at[s]) d_hold[s] = dv_val[s];
        #1;
        if (mvalid[s]) begin
            chk("d_valid", 8'(dv[s]), 8'(n == dv_at[s]));
            chk("d", d[s], d_hold[s]);
            chk("par", 8'(par[s]), 8'(^d_hold[s]));
            chk("busy", 8'(busy[s]), 8'(n < ready_at[s]));
            chk("pad", pad_of(s), (n == drv_at[s]) ? drv_val[s] : tb_val[s]);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int guard;
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0; rv[s] = 1'b0; rd[s] = 1'b0;
            a[s] = '0; b[s] = '0; tb_oe[s] = 1'b1; tb_val[s] = 8'hFF;
            idx[s] = 0; ready_at[s] = 0; dv_at[s] = -1; drv_at[s] = -1;
            recv_at[s] = -1; mvalid[s] = 1'b0; last_x[s] = '0; d_hold[s] = '0;
        end
        fix_en  = 1'b0;
        fix_val = '0;

        // Reset held three cycles, then release.
        repeat (3) step(0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, ok);
        chk("t1_d_rst", d[0], 8'h00);
        chk("t1_rdy_rst", 8'(rdy[0]), 8'h00);
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        chk("t1_rdy", 8'(rdy[0]), 8'h01);

        // Drive A5^0F with TURN_CYCLES=1.
        step(0, 1'b1, 1'b1, 8'hA5, 8'h0F, 1'b1, ok);
        chk("t2_pad", pad0, 8'hAA);
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        chk("t2_d", d[0], 8'hAA);
        chk("t2_dv", 8'(dv[0]), 8'h01);
        chk("t2_par", 8'(par[0]), 8'h00);
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        chk("t2_rdy", 8'(rdy[0]), 8'h01);

        // Receive 3C while the bench drives FF in RECV.
        fix_en  = 1'b1;
        fix_val = 8'hFF;
        step(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1, ok);
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        chk("t3_d", d[0], 8'hC3);
        chk("t3_dv", 8'(dv[0]), 8'h01);
        chk("t3_par", 8'(par[0]), 8'h00);
        fix_en = 1'b0;
        rst_n[0] = 1'b0;

        // TURN_CYCLES=3: drive immediately followed by receive.
        repeat (2) step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ok);
        step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        step(1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1, ok);
        guard = 0;
        do begin
            step(1, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1, ok);
            guard++;
        end while (!ok && guard < 20);
        if (!ok) begin
            total++; bad++;
            $display("FAIL t4_accept observed=none expected=accept within 20 cycles");
        end
        repeat (6) step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);

        // Reset during TURN of a receive, then a normal drive.
        step(1, 1'b1, 1'b0, 8'($urandom), 8'h00, 1'b1, ok);
        step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ok);
        chk("t5_busy", 8'(busy[1]), 8'h00);
        chk("t5_dv", 8'(dv[1]), 8'h00);
        repeat (5) step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
        step(1, 1'b1, 1'b1, 8'h5A, 8'h0F, 1'b1, ok);
        chk("t5_pad", pad1, 8'h55);
        repeat (5) step(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);

        // Held request with alternating direction on both instances.
        for (int s = 0; s < 2; s++) begin
            repeat (2) step(s, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ok);
            for (int i = 0; i < 20; i++)
                step(s, 1'b1, 1'(i % 2), 8'($urandom), 8'($urandom), 1'b1, ok);
            repeat (6) step(s, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
            rst_n[s] = 1'b0;
        end

        // Random traffic with occasional resets.
        for (int s = 0; s < 2; s++) begin
            step(s, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ok);
            for (int i = 0; i < 150; i++)
                step(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), 8'($urandom), ($urandom_range(0, 39) != 0), ok);
            repeat (6) step(s, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ok);
            rst_n[s] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
